// File: rtl/ex_madd_pkg.sv
// Shared execute-stage definitions for the multiply-accumulate path:
// bus widths, op/result-class codes and small arithmetic helpers.
package ex_madd_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;
    localparam int ALU_OP_BUS     = 8;
    localparam int ALU_SEL_BUS    = 3;

    localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [ALU_OP_BUS-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALU_OP_BUS-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALU_OP_BUS-1:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [ALU_OP_BUS-1:0] EXE_MADDU_OP = 8'b1010_0111;
    localparam logic [ALU_OP_BUS-1:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [ALU_OP_BUS-1:0] EXE_MSUBU_OP = 8'b1010_1011;

    localparam logic [ALU_SEL_BUS-1:0] EXE_RES_NOP  = 3'b000;
    localparam logic [ALU_SEL_BUS-1:0] EXE_RES_MULT = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } madd_state_e;

    function automatic logic is_accum_op(input logic [ALU_OP_BUS-1:0] op);
        logic r;
        case (op)
            EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_sub_op(input logic [ALU_OP_BUS-1:0] op);
        logic r;
        case (op)
            EXE_MSUB_OP, EXE_MSUBU_OP: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [DOUBLE_REG_BUS-1:0] twos_neg(input logic [DOUBLE_REG_BUS-1:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/ex_madd_hilo_fwd.sv
// Combinational HI/LO forwarding mux: MEM beats WB beats the register file.
// Shared with the MFHI/MFLO read path.
module hilo_fwd
    import ex_madd_pkg::*;
(
    input  logic               mem_whilo_i,
    input  logic [REG_BUS-1:0] mem_hi_i,
    input  logic [REG_BUS-1:0] mem_lo_i,
    input  logic               wb_whilo_i,
    input  logic [REG_BUS-1:0] wb_hi_i,
    input  logic [REG_BUS-1:0] wb_lo_i,
    input  logic [REG_BUS-1:0] hi_i,
    input  logic [REG_BUS-1:0] lo_i,
    output logic [REG_BUS-1:0] hi_o,
    output logic [REG_BUS-1:0] lo_o
);

    // Youngest pending write wins.
    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        if (mem_whilo_i) begin
            hi_o = mem_hi_i;
            lo_o = mem_lo_i;
        end else if (wb_whilo_i) begin
            hi_o = wb_hi_i;
            lo_o = wb_lo_i;
        end else begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end

endmodule

// File: rtl/ex_madd.sv
// Two-cycle MADD/MADDU/MSUB/MSUBU accumulate: latch the addend while stalling
// the pipe, then add it to the forwarded HI/LO and request the HI/LO write.
module ex_madd
    import ex_madd_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [ALU_OP_BUS-1:0]     aluop_i,
    input  logic [ALU_SEL_BUS-1:0]    alusel_i,
    input  logic [DOUBLE_REG_BUS-1:0] product_i,
    input  logic [REG_BUS-1:0]        hi_i,
    input  logic [REG_BUS-1:0]        lo_i,
    input  logic                      mem_whilo_i,
    input  logic [REG_BUS-1:0]        mem_hi_i,
    input  logic [REG_BUS-1:0]        mem_lo_i,
    input  logic                      wb_whilo_i,
    input  logic [REG_BUS-1:0]        wb_hi_i,
    input  logic [REG_BUS-1:0]        wb_lo_i,
    output logic [REG_BUS-1:0]        hi_o,
    output logic [REG_BUS-1:0]        lo_o,
    output logic                      whilo_o,
    output logic                      stallreq_o
);

    madd_state_e               state_q;
    madd_state_e               state_d_s;
    logic [DOUBLE_REG_BUS-1:0] addend_q;
    logic [DOUBLE_REG_BUS-1:0] addend_d_s;

    logic [REG_BUS-1:0]        fwd_hi_s;
    logic [REG_BUS-1:0]        fwd_lo_s;
    logic [DOUBLE_REG_BUS-1:0] sum_s;
    logic [DOUBLE_REG_BUS-1:0] new_addend_s;
    logic                      is_acc_s;

    logic [REG_BUS-1:0]        hi_s;
    logic [REG_BUS-1:0]        lo_s;
    logic                      whilo_s;
    logic                      stallreq_s;

    hilo_fwd u_hilo_fwd (
        .mem_whilo_i (mem_whilo_i),
        .mem_hi_i    (mem_hi_i),
        .mem_lo_i    (mem_lo_i),
        .wb_whilo_i  (wb_whilo_i),
        .wb_hi_i     (wb_hi_i),
        .wb_lo_i     (wb_lo_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .hi_o        (fwd_hi_s),
        .lo_o        (fwd_lo_s)
    );

    assign is_acc_s     = (alusel_i == EXE_RES_MULT) && is_accum_op(aluop_i);
    assign new_addend_s = is_sub_op(aluop_i) ? twos_neg(product_i) : product_i;
    // Signed and unsigned share this adder; the carry out of bit 63 is dropped.
    assign sum_s        = {fwd_hi_s, fwd_lo_s} + addend_q;

    // Next-state and output decode; flush overrides everything.
    always_comb begin
        state_d_s  = state_q;
        addend_d_s = addend_q;
        hi_s       = ZERO_WORD;
        lo_s       = ZERO_WORD;
        whilo_s    = 1'b0;
        stallreq_s = 1'b0;
        if (flush_i) begin
            state_d_s  = ST_IDLE;
            addend_d_s = 64'd0;
        end else if (is_acc_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!stall_i) begin
                        addend_d_s = new_addend_s;
                        stallreq_s = 1'b1;
                        state_d_s  = ST_ACCUM;
                    end else begin
                        state_d_s  = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    whilo_s = 1'b1;
                    hi_s    = sum_s[63:32];
                    lo_s    = sum_s[31:0];
                    if (!stall_i) begin
                        state_d_s = ST_IDLE;
                    end else begin
                        state_d_s = ST_ACCUM;
                    end
                end
                default: begin
                    state_d_s  = ST_IDLE;
                    addend_d_s = 64'd0;
                end
            endcase
        end else begin
            state_d_s  = state_q;
            addend_d_s = addend_q;
        end
    end

    // State and latched addend; async clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addend_q <= 64'd0;
        end else begin
            state_q  <= state_d_s;
            addend_q <= addend_d_s;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign hi_o       = rst ? hi_s       : ZERO_WORD;
    assign lo_o       = rst ? lo_s       : ZERO_WORD;
    assign whilo_o    = rst ? whilo_s    : 1'b0;
    assign stallreq_o = rst ? stallreq_s : 1'b0;

endmodule

// File: tb/tb_ex_madd.sv
// Scoreboard bench for ex_madd: stimulus queues expected HI/LO writes,
// a negedge monitor pops and compares whenever whilo_o is raised.
module tb_ex_madd;
    import ex_madd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [7:0]  aluop_i = EXE_NOP_OP;
    logic [2:0]  alusel_i = EXE_RES_NOP;
    logic [63:0] product_i = 64'd0;
    logic [31:0] hi_i = 32'd0, lo_i = 32'd0;
    logic        mem_whilo_i = 1'b0, wb_whilo_i = 1'b0;
    logic [31:0] mem_hi_i = 32'd0, mem_lo_i = 32'd0, wb_hi_i = 32'd0, wb_lo_i = 32'd0;
    logic [31:0] hi_o, lo_o;
    logic        whilo_o, stallreq_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    ex_madd dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .product_i   (product_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .mem_whilo_i (mem_whilo_i),
        .mem_hi_i    (mem_hi_i),
        .mem_lo_i    (mem_lo_i),
        .wb_whilo_i  (wb_whilo_i),
        .wb_hi_i     (wb_hi_i),
        .wb_lo_i     (wb_lo_i),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .whilo_o     (whilo_o),
        .stallreq_o  (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every HI/LO write request must match the oldest expected one.
    always @(negedge clk) begin
        if (whilo_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual hi=%h lo=%h required no write", hi_o, lo_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_hi"}, {32'd0, hi_o}, {32'd0, e.hi});
                chk({e.name, "_lo"}, {32'd0, lo_o}, {32'd0, e.lo});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        aluop_i     = EXE_NOP_OP;
        alusel_i    = EXE_RES_NOP;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        mem_whilo_i = 1'b0;
        wb_whilo_i  = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [63:0] prod,
                         input logic [31:0] chi, input logic [31:0] clo);
        aluop_i     = op;
        alusel_i    = EXE_RES_MULT;
        product_i   = prod;
        hi_i        = chi;
        lo_i        = clo;
        mem_whilo_i = 1'b0;
        wb_whilo_i  = 1'b0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
    endtask

    // Full two-cycle accumulate; product_i is scrambled in the second cycle
    // so the result must come from the latched addend.
    task automatic acc_op(input string name, input logic [7:0] op, input logic [63:0] prod,
                          input logic [31:0] chi, input logic [31:0] clo,
                          input logic [31:0] ehi, input logic [31:0] elo);
        issue(op, prod, chi, clo);
        @(negedge clk);
        chk({name, "_stallreq_n"}, {63'd0, stallreq_o}, 64'd1);
        chk({name, "_whilo_n"}, {63'd0, whilo_o}, 64'd0);
        tick();
        product_i = ~prod;
        exp_q.push_back('{hi: ehi, lo: elo, name: name});
        @(negedge clk);
        chk({name, "_stallreq_n1"}, {63'd0, stallreq_o}, 64'd1 - 64'd1);
        tick();
        idle_inputs();
    endtask

    initial begin
        // Reset held with an accumulate op presented: everything quiet.
        issue(EXE_MADD_OP, 64'd5, 32'd1, 32'd1);
        @(negedge clk);
        chk("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
        chk("rst_whilo", {63'd0, whilo_o}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();

        acc_op("madd", EXE_MADD_OP, 64'hFFFF_FFFF_FFFF_FFFA, 32'h0, 32'h10, 32'h0, 32'hA);
        acc_op("msubu", EXE_MSUBU_OP, 64'h1_0000_0000, 32'h1, 32'h0, 32'h0, 32'h0);
        acc_op("maddu_wrap", EXE_MADDU_OP, 64'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
        acc_op("msub_neg", EXE_MSUB_OP, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0, 32'h100, 32'h0, 32'h102);

        // Forwarding priority, sampled live in ACCUM.
        issue(EXE_MADD_OP, 64'd0, 32'd1, 32'h11);
        wb_whilo_i = 1'b1; wb_hi_i = 32'd2; wb_lo_i = 32'h22;
        mem_whilo_i = 1'b1; mem_hi_i = 32'd3; mem_lo_i = 32'h33;
        @(negedge clk);
        chk("fwd_stallreq", {63'd0, stallreq_o}, 64'd1);
        tick();
        stall_i = 1'b1;
        exp_q.push_back('{hi: 32'd3, lo: 32'h33, name: "fwd_mem"});
        tick();
        mem_whilo_i = 1'b0;
        stall_i = 1'b0;
        exp_q.push_back('{hi: 32'd2, lo: 32'h22, name: "fwd_wb"});
        tick();
        idle_inputs();

        // Two stall cycles in ACCUM: same write presented three times.
        issue(EXE_MADD_OP, 64'h10, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        stall_i = 1'b1;
        exp_q.push_back('{hi: 32'h1234_5678, lo: 32'h9ABC_DF00, name: "stall_c0"});
        @(negedge clk);
        chk("stall_stallreq", {63'd0, stallreq_o}, 64'd0);
        tick();
        exp_q.push_back('{hi: 32'h1234_5678, lo: 32'h9ABC_DF00, name: "stall_c1"});
        tick();
        stall_i = 1'b0;
        exp_q.push_back('{hi: 32'h1234_5678, lo: 32'h9ABC_DF00, name: "stall_c2"});
        tick();
        idle_inputs();
        @(negedge clk);
        chk("stall_exit_whilo", {63'd0, whilo_o}, 64'd0);
        tick();

        // Stall in IDLE: no latch, then retried.
        issue(EXE_MSUB_OP, 64'd3, 32'h0, 32'h5);
        stall_i = 1'b1;
        @(negedge clk);
        chk("idle_stall_stallreq", {63'd0, stallreq_o}, 64'd0);
        tick();
        acc_op("idle_retry", EXE_MSUB_OP, 64'd3, 32'h0, 32'h5, 32'h0, 32'h2);

        // Flush while in ACCUM.
        issue(EXE_MADD_OP, 64'd1, 32'h0, 32'h1);
        tick();
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_whilo", {63'd0, whilo_o}, 64'd0);
        chk("flush_hilo", {hi_o, lo_o}, 64'd0);
        tick();
        idle_inputs();
        aluop_i = EXE_MULT_OP; alusel_i = EXE_RES_MULT;
        @(negedge clk);
        chk("flush_mult_stallreq", {63'd0, stallreq_o}, 64'd0);
        chk("flush_mult_whilo", {63'd0, whilo_o}, 64'd0);
        tick();

        // Reset asserted mid-ACCUM.
        issue(EXE_MADD_OP, 64'd7, 32'h0, 32'h1);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_whilo", {63'd0, whilo_o}, 64'd0);
        chk("rstmid_hilo", {hi_o, lo_o}, 64'd0);
        aluop_i = EXE_MULT_OP;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_mult_stallreq", {63'd0, stallreq_o}, 64'd0);
        chk("rstmid_mult_whilo", {63'd0, whilo_o}, 64'd0);
        tick();

        // Accumulate opcode with the wrong result class is ignored.
        issue(EXE_MADD_OP, 64'd1, 32'h0, 32'h0);
        alusel_i = EXE_RES_NOP;
        @(negedge clk);
        chk("wrongsel_stallreq", {63'd0, stallreq_o}, 64'd0);
        tick();
        idle_inputs();
        tick();
        tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
